// File: rtl/wb_forward_unit.sv
// Writeback/forwarding end of the register-file lock: tracks in-flight writes through EX/MEM/WB.
// Issue to rd_wb is 3 posedges; stall freezes every slot; lookups are combinational.
module wb_forward_unit #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              issue_valid,
   input  logic [REG_W-1:0]  issue_rd,
   input  logic              issue_write,
   input  logic              issue_is_load,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [REG_W-1:0]  rs,
   input  logic [REG_W-1:0]  rt,
   output logic [REG_W-1:0]  rd_wb,
   output logic [DATA_W-1:0] result,
   output logic              forwarding_rs,
   output logic              forwarding_rt,
   output logic [DATA_W-1:0] fwd_rs_value,
   output logic [DATA_W-1:0] fwd_rt_value
);

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rd;
      logic              wr;
      logic              is_load;
      logic [DATA_W-1:0] data;
      logic              ready;
   } slot_t;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] value;
   } fwd_t;

   slot_t ex_q,  ex_d;
   slot_t mem_q, mem_d;
   slot_t wb_q,  wb_d;

   logic [REG_W-1:0]  rd_wb_q,  rd_wb_d;
   logic [DATA_W-1:0] result_q, result_d;

   fwd_t fwd_rs, fwd_rt;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!stall) begin
         ex_d.valid   = issue_valid;
         ex_d.rd      = issue_rd;
         ex_d.wr      = issue_write & (issue_rd != '0);
         ex_d.is_load = issue_is_load;
         ex_d.data    = '0;
         ex_d.ready   = 1'b0;

         // Loads carry no data until their MEM cycle completes.
         mem_d       = ex_q;
         mem_d.data  = ex_q.is_load ? '0 : ex_result;
         mem_d.ready = !ex_q.is_load;

         wb_d       = mem_q;
         wb_d.data  = mem_q.is_load ? mem_result : mem_q.data;
         wb_d.ready = 1'b1;
      end
   end

   // Writeback port is registered alongside the WB slot so it is stable all cycle.
   always_comb begin
      rd_wb_d  = '0;
      result_d = '0;
      if (wb_d.valid && wb_d.wr) begin
         rd_wb_d  = wb_d.rd;
         result_d = wb_d.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         rd_wb_q  <= '0;
         result_q <= '0;
      end else begin
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         wb_q     <= wb_d;
         rd_wb_q  <= rd_wb_d;
         result_q <= result_d;
      end
   end

   function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] idx);
      return s.valid && s.wr && (s.rd == idx) && (idx != '0);
   endfunction

   // Youngest match decides; an unready young match blocks older ready ones.
   function automatic fwd_t lookup(input logic [REG_W-1:0] idx,
                                   input slot_t ex_s, input slot_t mem_s, input slot_t wb_s);
      fwd_t f;
      f = '0;
      if (slot_match(ex_s, idx)) begin
         f.hit   = ex_s.ready;
         f.value = ex_s.ready ? ex_s.data : '0;
      end else if (slot_match(mem_s, idx)) begin
         f.hit   = mem_s.ready;
         f.value = mem_s.ready ? mem_s.data : '0;
      end else if (slot_match(wb_s, idx)) begin
         f.hit   = wb_s.ready;
         f.value = wb_s.ready ? wb_s.data : '0;
      end
      return f;
   endfunction

   always_comb begin
      fwd_rs = lookup(rs, ex_q, mem_q, wb_q);
      fwd_rt = lookup(rt, ex_q, mem_q, wb_q);
   end

   assign rd_wb         = rd_wb_q;
   assign result        = result_q;
   assign forwarding_rs = fwd_rs.hit;
   assign forwarding_rt = fwd_rt.hit;
   assign fwd_rs_value  = fwd_rs.value;
   assign fwd_rt_value  = fwd_rt.value;

endmodule

// File: tb/tb_wb_forward_unit.sv
// Scoreboard bench for wb_forward_unit: instructions indexed by advance count, checked at negedge.
module tb_wb_forward_unit;

   logic        clk = 1'b0;
   logic        reset, stall, issue_valid, issue_write, issue_is_load;
   logic [4:0]  issue_rd, rs, rt;
   logic [31:0] ex_result, mem_result;
   logic [4:0]  rd_wb;
   logic [31:0] result, fwd_rs_value, fwd_rt_value;
   logic        forwarding_rs, forwarding_rt;

   always #5 clk = ~clk;

   wb_forward_unit dut (
      .clk(clk), .reset(reset), .stall(stall),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_write(issue_write),
      .issue_is_load(issue_is_load), .ex_result(ex_result), .mem_result(mem_result),
      .rs(rs), .rt(rt), .rd_wb(rd_wb), .result(result),
      .forwarding_rs(forwarding_rs), .forwarding_rt(forwarding_rt),
      .fwd_rs_value(fwd_rs_value), .fwd_rt_value(fwd_rt_value)
   );

   typedef struct {
      logic [4:0]  rd_wb;
      logic [31:0] result;
      logic        frs;
      logic [31:0] vrs;
      logic        frt;
      logic [31:0] vrt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Instruction j was captured at the j-th unstalled edge since reset.
   // After n advances: EX holds j=n, MEM j=n-1, WB j=n-2.
   localparam int DEPTH = 4096;
   bit          m_v  [DEPTH];
   bit          m_wr [DEPTH];
   bit          m_ld [DEPTH];
   logic [4:0]  m_rd [DEPTH];
   logic [31:0] m_ex [DEPTH];
   logic [31:0] m_mem[DEPTH];
   int          n = 0;

   function automatic bit mvalid(input int j);
      return (j >= 1) && m_v[j];
   endfunction

   // ALU result is ex_result seen at the edge leaving EX; load data is mem_result at the edge leaving MEM.
   function automatic logic [31:0] mdata(input int j);
      return m_ld[j] ? m_mem[j+2] : m_ex[j+1];
   endfunction

   task automatic mfwd(input logic [4:0] r, output logic hit, output logic [31:0] v);
      bit found;
      hit = 1'b0;
      v = '0;
      found = 1'b0;
      if (r != 5'd0) begin
         for (int j = n; j >= n - 2; j--) begin
            if (!found && mvalid(j) && m_wr[j] && m_rd[j] == r) begin
               found = 1'b1;
               if (j == n - 2 || (j == n - 1 && !m_ld[j])) begin
                  hit = 1'b1;
                  v = mdata(j);
               end
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic iv, input logic [4:0] ird,
                       input logic iw, input logic il, input logic [31:0] exr,
                       input logic [31:0] memr, input logic [4:0] a, input logic [4:0] b);
      exp_t e;
      int   w;
      @(posedge clk);
      if (reset) begin
         n = 0;
      end else if (!stall) begin
         n++;
         m_v[n]   = issue_valid;
         m_rd[n]  = issue_rd;
         m_wr[n]  = issue_write && (issue_rd != 5'd0);
         m_ld[n]  = issue_is_load;
         m_ex[n]  = ex_result;
         m_mem[n] = mem_result;
      end
      #1;
      reset = r; stall = s; issue_valid = iv; issue_rd = ird; issue_write = iw;
      issue_is_load = il; ex_result = exr; mem_result = memr; rs = a; rt = b;
      w = n - 2;
      if (mvalid(w) && m_wr[w]) begin
         e.rd_wb  = m_rd[w];
         e.result = mdata(w);
      end else begin
         e.rd_wb  = '0;
         e.result = '0;
      end
      mfwd(a, e.frs, e.vrs);
      mfwd(b, e.frt, e.vrt);
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_wb",         {27'd0, rd_wb},         {27'd0, e.rd_wb});
            chk("result",        result,                 e.result);
            chk("forwarding_rs", {31'd0, forwarding_rs}, {31'd0, e.frs});
            chk("fwd_rs_value",  fwd_rs_value,           e.vrs);
            chk("forwarding_rt", {31'd0, forwarding_rt}, {31'd0, e.frt});
            chk("fwd_rt_value",  fwd_rt_value,           e.vrt);
         end
      end
   end

   initial begin : stim
      logic [4:0] rd_r;
      reset = 1'b1; stall = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_write = 1'b0;
      issue_is_load = 1'b0; ex_result = '0; mem_result = '0; rs = '0; rt = '0;
      // r, s, iv, rd, wr, ld, ex_result, mem_result, rs, rt
      repeat (3) step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

      // ALU r5 = 0x11 followed by bubbles, rs=5
      step(0, 0, 1, 5, 1, 0, 32'h0,  32'h0, 5, 0);
      step(0, 0, 0, 0, 0, 0, 32'h11, 32'h0, 5, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 5, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 5, 0);

      // load r7 = 0xABCD, rt=7
      step(0, 0, 1, 7, 1, 1, 32'h0, 32'h0,    0, 7);
      step(0, 0, 0, 0, 0, 0, 32'h9, 32'h0,    0, 7);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'hABCD, 0, 7);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0,    0, 7);

      // back-to-back r3 = 1 then r3 = 2
      step(0, 0, 1, 3, 1, 0, 32'h0, 32'h0, 3, 3);
      step(0, 0, 1, 3, 1, 0, 32'h1, 32'h0, 3, 3);
      step(0, 0, 0, 0, 0, 0, 32'h2, 32'h0, 3, 3);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3, 3);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3, 3);

      // write to r0 is never tracked
      step(0, 0, 1, 0, 1, 0, 32'h0,  32'h0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'hFF, 32'h0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 0, 0);

      // stall two cycles with a load in MEM
      step(0, 0, 1, 9, 1, 1, 32'h0, 32'h0,    9, 9);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0,    9, 9);
      step(0, 1, 0, 0, 0, 0, 32'h0, 32'hDEAD, 9, 9);
      step(0, 1, 0, 0, 0, 0, 32'h0, 32'hBEEF, 9, 9);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h5555, 9, 9);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0,    9, 9);
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0,    9, 9);

      // reset with all three slots valid, stall also asserted
      step(0, 0, 1, 4, 1, 0, 32'h0,  32'h0, 4, 6);
      step(0, 0, 1, 6, 1, 1, 32'h44, 32'h0, 4, 6);
      step(0, 0, 1, 8, 1, 0, 32'h0,  32'h66, 4, 8);
      step(1, 1, 0, 0, 0, 0, 32'h88, 32'h0, 4, 8);
      step(0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 4, 8);
      step(0, 0, 0, 0, 0, 0, 32'h0,  32'h0, 4, 8);

      for (int i = 0; i < 1500; i++) begin
         rd_r = 5'($urandom_range(0, 7));
         step(($urandom_range(0, 99) < 2),
              ($urandom_range(0, 99) < 20),
              ($urandom_range(0, 99) < 80),
              rd_r,
              ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 35),
              $urandom, $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expected responses left unchecked, required 0", sb.size());
      end
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
